// File: rtl/eco32f_rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// eco32f_rf_wport_arbiter : RF write-port arbiter (pipeline vs. buffered LDU)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module eco32f_rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_rf_we,
  input  logic [4:0]  pipe_rf_addr,
  input  logic [31:0] pipe_rf_data,
  output logic        pipe_hold,
  input  logic        ldu_issue,
  input  logic [4:0]  ldu_issue_addr,
  input  logic        ldu_valid,
  input  logic [4:0]  ldu_addr,
  input  logic [31:0] ldu_data,
  output logic        ldu_ready,
  input  logic [4:0]  dec_rs_addr,
  input  logic [4:0]  dec_rt_addr,
  input  logic [4:0]  dec_rd_addr,
  output logic        dec_hazard,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(STARVE_LIMIT - 1);

  logic [4:0]       fifo_addr_q [FIFO_DEPTH];
  logic [4:0]       fifo_addr_d [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             pipe_hold_q, pipe_hold_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic             rf_src_ldu_q, rf_src_ldu_d;
  logic [31:0]      busy_q, busy_d;

  logic        fifo_empty, fifo_full, push;
  logic        grant_pipe, grant_fifo;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign push       = ldu_valid && !fifo_full;

  always_comb begin
    grant_pipe   = 1'b0;
    grant_fifo   = 1'b0;
    gnt_addr     = fifo_addr_q[rd_ptr_q];
    gnt_data     = fifo_data_q[rd_ptr_q];
    fifo_addr_d  = fifo_addr_q;
    fifo_data_d  = fifo_data_q;
    starve_cnt_d = '0;
    pipe_hold_d  = 1'b0;
    busy_d       = busy_q;

    // A hold cycle belongs to the FIFO; the pipeline re-presents next cycle.
    if (pipe_hold_q) begin
      grant_fifo = 1'b1;
    end else if (pipe_rf_we) begin
      grant_pipe = 1'b1;
      gnt_addr   = pipe_rf_addr;
      gnt_data   = pipe_rf_data;
    end else if (!fifo_empty) begin
      grant_fifo = 1'b1;
    end

    rf_we_d      = (grant_pipe || grant_fifo) && (gnt_addr != 5'd0);
    rf_addr_d    = (grant_pipe || grant_fifo) ? gnt_addr : rf_addr_q;
    rf_data_d    = (grant_pipe || grant_fifo) ? gnt_data : rf_data_q;
    rf_src_ldu_d = grant_fifo;

    if (push) begin
      fifo_addr_d[wr_ptr_q] = ldu_addr;
      fifo_data_d[wr_ptr_q] = ldu_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(grant_fifo);
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(grant_fifo);

    if (grant_pipe && !fifo_empty) begin
      if (starve_cnt_q == LIMIT_M1_C) begin
        pipe_hold_d = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end

    // Clear first so that a same-edge re-issue keeps the register busy.
    if (rf_we_q && rf_src_ldu_q) begin
      busy_d[rf_addr_q] = 1'b0;
    end
    if (ldu_issue && (ldu_issue_addr != 5'd0)) begin
      busy_d[ldu_issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      pipe_hold_q  <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      rf_src_ldu_q <= 1'b0;
      busy_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      pipe_hold_q  <= pipe_hold_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      rf_src_ldu_q <= rf_src_ldu_d;
      busy_q       <= busy_d;
    end
  end

  assign pipe_hold  = pipe_hold_q;
  assign ldu_ready  = !fifo_full;
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign dec_hazard = busy_q[dec_rs_addr] || busy_q[dec_rt_addr] || busy_q[dec_rd_addr];

endmodule

`default_nettype wire
